// File: rtl/stage_hs_pkg.sv
// Shared types and constants for the stage_hs elastic pipeline stage.
package stage_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   // Direction encoding carried on opcode bit RX_TX_BIT.
   typedef enum logic {
      OP_RX = 1'b0,
      OP_TX = 1'b1
   } op_dir_e;

   localparam int RX_TX_BIT = 0;

   // Packed width of one beat: opcode, soft-error flag, DPP and NDT.
   function automatic int skid_width(int opcode_size, int data_size, int tag_size);
      return opcode_size + 1 + (data_size + 1) + (data_size + tag_size);
   endfunction

endpackage

// File: rtl/stage_hs_if.sv
// Handshake and payload bundle between the front end and the RX/TX datapath mux.
interface stage_hs_if #(
   parameter int data_size   = 32,
   parameter int tag_size    = 8,
   parameter int opcode_size = 2,
   parameter int cnt_size    = 8
);
   logic                          in_valid;
   logic                          in_ready;
   logic [opcode_size-1:0]        opcode_in;
   logic                          soft_error_in;
   logic [data_size:0]            dpp_in;
   logic [data_size+tag_size-1:0] ndt_in;

   logic                          out_valid;
   logic                          out_ready;
   logic [opcode_size-1:0]        opcode_out;
   logic                          soft_error_out;
   logic [data_size:0]            dpp_out;
   logic [data_size+tag_size-1:0] ndt_out;

   logic                          rx_tx;
   logic [data_size-1:0]          tx_data;
   logic [data_size-1:0]          rx_data;
   logic [tag_size-1:0]           rx_tag;
   logic                          parity_err;
   logic [cnt_size-1:0]           soft_err_cnt;

   modport slave (
      input  in_valid, opcode_in, soft_error_in, dpp_in, ndt_in, out_ready,
      output in_ready, out_valid, opcode_out, soft_error_out, dpp_out, ndt_out,
             rx_tx, tx_data, rx_data, rx_tag, parity_err, soft_err_cnt
   );

   modport master (
      output in_valid, opcode_in, soft_error_in, dpp_in, ndt_in, out_ready,
      input  in_ready, out_valid, opcode_out, soft_error_out, dpp_out, ndt_out,
             rx_tx, tx_data, rx_data, rx_tag, parity_err, soft_err_cnt
   );
endinterface

// File: rtl/stage_hs_skid.sv
// Generic two-entry skid buffer: main register drives the output, the skid
// register absorbs the beat accepted in the cycle the downstream stalls.
module stage_skid
   import stage_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   state_e       r_state;
   state_e       w_next_state;
   logic [W-1:0] r_main;
   logic [W-1:0] r_skid;
   logic         w_accept;
   logic         w_retire;
   logic         w_load_main;
   logic         w_load_skid;
   logic         w_move;

   // Ready is a pure decode of the state register: no path from i_ready.
   assign o_ready  = (r_state != TWO);
   assign o_valid  = (r_state != EMPTY);
   assign o_data   = r_main;
   assign w_accept = i_valid && o_ready;
   assign w_retire = o_valid && i_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= EMPTY;
      else          r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_load_main  = 1'b0;
      w_load_skid  = 1'b0;
      w_move       = 1'b0;
      if (i_flush) begin
         w_next_state = EMPTY;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_next_state = ONE;
                  w_load_main  = 1'b1;
               end
            end
            ONE: begin
               if (w_accept && w_retire) begin
                  w_load_main  = 1'b1;
               end else if (w_retire) begin
                  w_next_state = EMPTY;
               end else if (w_accept) begin
                  w_next_state = TWO;
                  w_load_skid  = 1'b1;
               end
            end
            TWO: begin
               if (w_retire) begin
                  w_next_state = ONE;
                  w_move       = 1'b1;
               end
            end
            default: w_next_state = EMPTY;
         endcase
      end
   end

   // NOTE: payload registers are reset too, because the outputs must read zero while in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main)  r_main <= i_data;
         else if (w_move)  r_main <= r_skid;
         if (w_load_skid)  r_skid <= i_data;
      end
   end

endmodule

// File: rtl/stage_hs.sv
// Elastic stage-2 between the host/network front end and the RX/TX mux: skid
// buffered beat transport plus RX/TX decode, output parity recheck and soft-error count.
module stage_hs
   import stage_pkg::*;
#(
   parameter int data_size   = 32,
   parameter int tag_size    = 8,
   parameter int opcode_size = 2,
   parameter int cnt_size    = 8
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     flush,
   stage_hs_if.slave bus
);

   localparam int NDT_W   = data_size + tag_size;
   localparam int DPP_W   = data_size + 1;
   localparam int DPP_LSB = NDT_W;
   localparam int SE_BIT  = NDT_W + DPP_W;
   localparam int W       = skid_width(opcode_size, data_size, tag_size);

   logic [W-1:0]           w_in_data;
   logic [W-1:0]           w_out_data;
   logic [opcode_size-1:0] w_opcode;
   logic [DPP_W-1:0]       w_dpp;
   logic [NDT_W-1:0]       w_ndt;
   logic                   w_count_en;
   logic [cnt_size-1:0]    r_soft_err_cnt;

   assign w_in_data = {bus.opcode_in, bus.soft_error_in, bus.dpp_in, bus.ndt_in};

   stage_skid #(.W(W)) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (flush),
      .i_valid (bus.in_valid),
      .o_ready (bus.in_ready),
      .i_data  (w_in_data),
      .o_valid (bus.out_valid),
      .i_ready (bus.out_ready),
      .o_data  (w_out_data)
   );

   assign w_opcode = w_out_data[W-1 -: opcode_size];
   assign w_dpp    = w_out_data[DPP_LSB +: DPP_W];
   assign w_ndt    = w_out_data[NDT_W-1:0];

   assign bus.opcode_out     = w_opcode;
   assign bus.soft_error_out = w_out_data[SE_BIT];
   assign bus.dpp_out        = w_dpp;
   assign bus.ndt_out        = w_ndt;

   assign bus.rx_tx      = (op_dir_e'(w_opcode[RX_TX_BIT]) == OP_TX);
   assign bus.tx_data    = w_dpp[data_size:1];
   assign bus.rx_data    = w_ndt[NDT_W-1:tag_size];
   assign bus.rx_tag     = w_ndt[tag_size-1:0];
   assign bus.parity_err = bus.out_valid && (^w_dpp);

   // Beats dropped by flush are never counted; flush leaves the count alone.
   assign w_count_en = bus.in_valid && bus.in_ready && !flush && bus.soft_error_in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_soft_err_cnt <= '0;
      end else if (w_count_en && (r_soft_err_cnt != {cnt_size{1'b1}})) begin
         r_soft_err_cnt <= r_soft_err_cnt + cnt_size'(1);
      end
   end

   assign bus.soft_err_cnt = r_soft_err_cnt;

endmodule

// File: tb/tb_stage_hs.sv
// Scoreboard bench for stage_hs: accepted beats are queued, a negedge monitor
// pops and compares every retired beat; directed checks cover reset, stall, decode, flush, saturation.
module tb_stage_hs;
   import stage_pkg::*;

   localparam int DS = 32;
   localparam int TS = 8;
   localparam int OS = 2;
   localparam int CS = 2;
   localparam int CNT_MAX = (1 << CS) - 1;

   typedef struct packed {
      logic [OS-1:0]    op;
      logic             se;
      logic [DS:0]      dpp;
      logic [DS+TS-1:0] ndt;
   } beat_t;

   logic clk;
   logic reset_n;
   logic flush;

   stage_hs_if #(.data_size(DS), .tag_size(TS), .opcode_size(OS), .cnt_size(CS)) bus ();

   stage_hs #(.data_size(DS), .tag_size(TS), .opcode_size(OS), .cnt_size(CS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus.slave)
   );

   beat_t q[$];
   int    total   = 0;
   int    bad     = 0;
   int    n_ret   = 0;
   int    exp_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t mk(logic [OS-1:0] op, logic se, logic [DS-1:0] d,
                                logic [DS-1:0] nd, logic [TS-1:0] tag);
      beat_t b;
      b.op  = op;
      b.se  = se;
      b.dpp = {d, ^d};
      b.ndt = {nd, tag};
      return b;
   endfunction

   task automatic drive(input beat_t b);
      bus.opcode_in     = b.op;
      bus.soft_error_in = b.se;
      bus.dpp_in        = b.dpp;
      bus.ndt_in        = b.ndt;
   endtask

   // Offer a beat until the handshake completes; returns #1 after the accepting edge.
   task automatic send(input beat_t b);
      bit done = 1'b0;
      drive(b);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1'b1;
            if (!flush) begin
               q.push_back(b);
               if (b.se && exp_cnt < CNT_MAX) exp_cnt++;
            end
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout: beat %0h never accepted", b.dpp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every retired beat must match the oldest accepted beat.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (reset_n && !flush && bus.out_valid && bus.out_ready) begin
            n_ret++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL mon_unexpected: got beat dpp=%0h with nothing pending", bus.dpp_out);
            end else begin
               e = q.pop_front();
               check("mon_opcode", bus.opcode_out, e.op);
               check("mon_soft_err", bus.soft_error_out, e.se);
               check("mon_dpp", bus.dpp_out, e.dpp);
               check("mon_ndt", bus.ndt_out, e.ndt);
               check("mon_rx_tx", bus.rx_tx, e.op[0]);
               check("mon_tx_data", bus.tx_data, e.dpp[DS:1]);
               check("mon_rx_data", bus.rx_data, e.ndt[DS+TS-1:TS]);
               check("mon_rx_tag", bus.rx_tag, e.ndt[TS-1:0]);
               check("mon_parity", bus.parity_err, ^e.dpp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b1, b2, d1, d2;
      int    ret0;
      int    sat_exp[5] = '{1, 2, 3, 3, 3};

      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(mk(2'b00, 1'b0, '0, '0, '0));

      // Reset state
      #3;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_dpp", bus.dpp_out, 0);
      check("rst_ndt", bus.ndt_out, 0);
      check("rst_cnt", bus.soft_err_cnt, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back stream with out_ready high
      bus.out_ready = 1'b1;
      ret0 = n_ret;
      for (int i = 0; i < 8; i++) begin
         send(mk(OS'(i), 1'b0, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i * 3), TS'(i * 17)));
         if (i == 0) check("stream_latency", bus.out_valid, 1);
         check("stream_in_ready", bus.in_ready, 1);
      end
      cycles(3);
      check("stream_retired", n_ret - ret0, 8);
      check("stream_pending", q.size(), 0);

      // Back-pressure: two beats fill the buffer, the third is held off
      bus.out_ready = 1'b0;
      b1 = mk(2'b01, 1'b0, 32'h0BAD_0001, 32'hCAFE_0001, 8'h11);
      b2 = mk(2'b10, 1'b0, 32'h0BAD_0002, 32'hCAFE_0002, 8'h22);
      send(b1);
      send(b2);
      check("bp_in_ready_full", bus.in_ready, 0);
      drive(mk(2'b11, 1'b0, 32'h0BAD_0003, 32'hCAFE_0003, 8'h33));
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready_hold", bus.in_ready, 0);
         check("bp_head_dpp", bus.dpp_out, b1.dpp);
         check("bp_head_ndt", bus.ndt_out, b1.ndt);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      ret0          = n_ret;
      bus.out_ready = 1'b1;
      cycles(3);
      check("bp_retired", n_ret - ret0, 2);
      check("bp_in_ready_back", bus.in_ready, 1);
      check("bp_pending", q.size(), 0);

      // Decode and parity recheck
      bus.out_ready = 1'b0;
      d1 = mk(2'b01, 1'b0, 32'hA5A5_0001, 32'hDEAD_BEEF, 8'h3C);
      send(d1);
      check("dec_rx_tx", bus.rx_tx, 1);
      check("dec_tx_data", bus.tx_data, 32'hA5A5_0001);
      check("dec_rx_data", bus.rx_data, 32'hDEAD_BEEF);
      check("dec_rx_tag", bus.rx_tag, 8'h3C);
      check("dec_parity_ok", bus.parity_err, 0);
      bus.out_ready = 1'b1;
      cycles(1);
      bus.out_ready = 1'b0;
      d2 = d1;
      d2.dpp[0] = ~d1.dpp[0];
      send(d2);
      check("dec_parity_bad", bus.parity_err, 1);
      bus.out_ready = 1'b1;
      cycles(2);
      check("dec_pending", q.size(), 0);

      // Flush in TWO while a beat is offered
      bus.out_ready = 1'b0;
      send(mk(2'b00, 1'b1, 32'hF100_0001, 32'hF200_0001, 8'h01));
      send(mk(2'b01, 1'b0, 32'hF100_0002, 32'hF200_0002, 8'h02));
      check("fl_cnt_before", bus.soft_err_cnt, exp_cnt);
      drive(mk(2'b01, 1'b1, 32'hF100_0003, 32'hF200_0003, 8'h03));
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      cycles(1);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      check("fl_two_out_valid", bus.out_valid, 0);
      check("fl_two_in_ready", bus.in_ready, 1);
      check("fl_two_cnt", bus.soft_err_cnt, exp_cnt);

      // Flush in ONE, where the offered beat would otherwise be accepted
      send(mk(2'b10, 1'b0, 32'hF100_0004, 32'hF200_0004, 8'h04));
      drive(mk(2'b11, 1'b1, 32'hF100_0005, 32'hF200_0005, 8'h05));
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      cycles(1);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      check("fl_one_out_valid", bus.out_valid, 0);
      check("fl_one_cnt", bus.soft_err_cnt, exp_cnt);
      ret0          = n_ret;
      bus.out_ready = 1'b1;
      cycles(3);
      check("fl_nothing_out", n_ret - ret0, 0);

      // Asynchronous reset pulse mid-stall
      bus.out_ready = 1'b0;
      send(mk(2'b11, 1'b1, 32'hEEEE_1111, 32'h7777_8888, 8'h99));
      send(mk(2'b01, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 8'h55));
      check("ar_cnt_before", bus.soft_err_cnt, exp_cnt);
      #3 reset_n = 1'b0;
      #1;
      check("ar_out_valid", bus.out_valid, 0);
      check("ar_in_ready", bus.in_ready, 1);
      check("ar_opcode", bus.opcode_out, 0);
      check("ar_soft_err", bus.soft_error_out, 0);
      check("ar_dpp", bus.dpp_out, 0);
      check("ar_ndt", bus.ndt_out, 0);
      check("ar_rx_tx", bus.rx_tx, 0);
      check("ar_tx_data", bus.tx_data, 0);
      check("ar_rx_data", bus.rx_data, 0);
      check("ar_rx_tag", bus.rx_tag, 0);
      check("ar_parity", bus.parity_err, 0);
      check("ar_cnt", bus.soft_err_cnt, 0);
      q.delete();
      exp_cnt = 0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Soft-error counter saturation
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(mk(2'b00, 1'b1, 32'h5A00_0000 + 32'(i), 32'h6B00_0000 + 32'(i), 8'hC0));
         check("sat_cnt", bus.soft_err_cnt, sat_exp[i]);
      end
      cycles(3);
      check("final_pending", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
